// File: rtl/shadow_dump_collector.sv
// Collects the serial shadow-chain dump into WORD_W-bit words, round-robin arbitrated onto one stream.
// Latency: a completing bit sampled at edge k fills the holding slot at k and the output at k+1.
// Backpressure: out_ready low stalls the output register and then the slots; further words are dropped and flagged in overflow.
module shadow_dump_collector #(
    parameter int CHAINS = 64,
    parameter int WORD_W = 32,
    parameter int CW     = $clog2(CHAINS),
    parameter int LW     = $clog2(WORD_W) + 1
) (
    input  logic              gclk,
    input  logic              arst_l,
    input  logic              start,
    output logic [CHAINS-1:0] dump_en,
    input  logic [CHAINS-1:0] ch_out,
    input  logic [CHAINS-1:0] ch_out_vld,
    input  logic [CHAINS-1:0] ch_out_done,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [WORD_W-1:0] out_data,
    output logic [LW-1:0]     out_len,
    output logic [CW-1:0]     out_chain,
    output logic              out_last,
    output logic              busy,
    output logic              done,
    output logic [CHAINS-1:0] overflow
);

    localparam int BW = $clog2(WORD_W);

    typedef enum logic [1:0] {IDLE, DUMP, DRAIN} state_t;

    state_t            state, state_nxt;
    logic [CW-1:0]     rr;
    logic              start_acc;

    // per-chain deserializer and holding slot
    logic [WORD_W-1:0] sh        [CHAINS];
    logic [BW-1:0]     cnt       [CHAINS];
    logic [CHAINS-1:0] done_seen;
    logic [CHAINS-1:0] slot_full;
    logic [CHAINS-1:0] slot_last;
    logic [WORD_W-1:0] slot_data [CHAINS];
    logic [LW-1:0]     slot_len  [CHAINS];

    logic [CHAINS-1:0] take_bit, take_done, full_word, prod, gnt_hit, slot_free;
    logic [WORD_W-1:0] prod_data [CHAINS];
    logic [LW-1:0]     prod_len  [CHAINS];

    logic              load, gnt_vld;
    logic [CW-1:0]     gnt_idx;
    logic [CW:0]       scan;

    assign start_acc = (state == IDLE) && start;
    assign dump_en   = {CHAINS{state == DUMP}};
    assign busy      = (state != IDLE);

    // next state: done_seen gates the end of DUMP, empty slots plus empty output end DRAIN
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = DUMP;
            DUMP:    if (&done_seen) state_nxt = DRAIN;
            DRAIN:   if (!(|slot_full) && !out_valid) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // per-chain word assembly: the bit landing this cycle is merged into the produced word
    always_comb begin
        for (int i = 0; i < CHAINS; i++) begin
            take_bit[i]  = (state == DUMP) && !done_seen[i] && ch_out_vld[i];
            take_done[i] = (state == DUMP) && !done_seen[i] && ch_out_done[i];
            prod_data[i] = sh[i];
            if (take_bit[i]) prod_data[i][cnt[i]] = ch_out[i];
            full_word[i] = take_bit[i] && (cnt[i] == BW'(WORD_W - 1));
            prod[i]      = full_word[i] || take_done[i];
            prod_len[i]  = full_word[i] ? LW'(WORD_W) : (LW'(cnt[i]) + LW'(take_bit[i]));
        end
    end

    // round-robin grant: first full slot at or after rr, only when the output register can load
    always_comb begin
        load    = !out_valid || out_ready;
        gnt_vld = 1'b0;
        gnt_idx = '0;
        scan    = '0;
        for (int k = 0; k < CHAINS; k++) begin
            scan = {1'b0, rr} + (CW+1)'(k);
            if (scan >= (CW+1)'(CHAINS)) scan = scan - (CW+1)'(CHAINS);
            if (load && !gnt_vld && slot_full[scan[CW-1:0]]) begin
                gnt_vld = 1'b1;
                gnt_idx = scan[CW-1:0];
            end
        end
        for (int i = 0; i < CHAINS; i++) begin
            gnt_hit[i]   = gnt_vld && (gnt_idx == CW'(i));
            slot_free[i] = !slot_full[i] || gnt_hit[i];
        end
    end

    // FSM state, done pulse on the DRAIN->IDLE edge, round-robin pointer
    always_ff @(posedge gclk or negedge arst_l) begin
        if (!arst_l) begin
            state <= IDLE;
            done  <= 1'b0;
            rr    <= '0;
        end else begin
            state <= state_nxt;
            done  <= (state == DRAIN) && (state_nxt == IDLE);
            if (gnt_vld) rr <= (gnt_idx == CW'(CHAINS - 1)) ? '0 : gnt_idx + CW'(1);
        end
    end

    // deserializers, holding slots and sticky overflow; start wipes everything from a previous dump
    always_ff @(posedge gclk or negedge arst_l) begin
        if (!arst_l) begin
            for (int i = 0; i < CHAINS; i++) begin
                sh[i]        <= '0;
                cnt[i]       <= '0;
                slot_data[i] <= '0;
                slot_len[i]  <= '0;
            end
            done_seen <= '0;
            slot_full <= '0;
            slot_last <= '0;
            overflow  <= '0;
        end else if (start_acc) begin
            for (int i = 0; i < CHAINS; i++) begin
                sh[i]  <= '0;
                cnt[i] <= '0;
            end
            done_seen <= '0;
            slot_full <= '0;
            overflow  <= '0;
        end else begin
            for (int i = 0; i < CHAINS; i++) begin
                if (prod[i]) begin
                    sh[i]  <= '0;
                    cnt[i] <= '0;
                end else if (take_bit[i]) begin
                    sh[i]  <= prod_data[i];
                    cnt[i] <= cnt[i] + BW'(1);
                end
                if (take_done[i]) done_seen[i] <= 1'b1;
                if (prod[i] && slot_free[i]) begin
                    slot_full[i] <= 1'b1;
                    slot_data[i] <= prod_data[i];
                    slot_len[i]  <= prod_len[i];
                    slot_last[i] <= take_done[i];
                end else if (gnt_hit[i]) begin
                    slot_full[i] <= 1'b0;
                end
                if (prod[i] && !slot_free[i]) overflow[i] <= 1'b1;
            end
        end
    end

    // output register: holds while stalled, reloads from the granted slot otherwise
    always_ff @(posedge gclk or negedge arst_l) begin
        if (!arst_l) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_len   <= '0;
            out_chain <= '0;
            out_last  <= 1'b0;
        end else if (load) begin
            out_valid <= gnt_vld;
            if (gnt_vld) begin
                out_data  <= slot_data[gnt_idx];
                out_len   <= slot_len[gnt_idx];
                out_chain <= gnt_idx;
                out_last  <= slot_last[gnt_idx];
            end
        end
    end

endmodule

// File: tb/tb_shadow_dump_collector.sv
// Directed bench for shadow_dump_collector with 4 chains of 8-bit words.
// Latency: words are collected from the output stream on the falling edge before their accepting edge.
// Backpressure: out_ready is driven by the stimulus to exercise stalls and slot overflow.
module tb_shadow_dump_collector;

    localparam int CHAINS = 4;
    localparam int WORD_W = 8;
    localparam int CW     = 2;
    localparam int LW     = 4;

    logic              gclk;
    logic              arst_l;
    logic              start;
    logic [CHAINS-1:0] dump_en;
    logic [CHAINS-1:0] ch_out;
    logic [CHAINS-1:0] ch_out_vld;
    logic [CHAINS-1:0] ch_out_done;
    logic              out_valid;
    logic              out_ready;
    logic [WORD_W-1:0] out_data;
    logic [LW-1:0]     out_len;
    logic [CW-1:0]     out_chain;
    logic              out_last;
    logic              busy;
    logic              done;
    logic [CHAINS-1:0] overflow;

    int vectors     = 0;
    int miscompares = 0;
    int cyc         = 0;

    logic [63:0] cap [$];
    int          cap_cyc [$];

    shadow_dump_collector #(.CHAINS(CHAINS), .WORD_W(WORD_W)) dut (
        .gclk        (gclk),
        .arst_l      (arst_l),
        .start       (start),
        .dump_en     (dump_en),
        .ch_out      (ch_out),
        .ch_out_vld  (ch_out_vld),
        .ch_out_done (ch_out_done),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_data    (out_data),
        .out_len     (out_len),
        .out_chain   (out_chain),
        .out_last    (out_last),
        .busy        (busy),
        .done        (done),
        .overflow    (overflow)
    );

    initial begin
        gclk = 1'b0;
        forever #5 gclk = ~gclk;
    end

    always @(posedge gclk) cyc++;

    // inputs change 1 after the rising edge, so the falling edge sees the handshake of the next rising edge
    always @(negedge gclk) begin
        if (arst_l && out_valid && out_ready) begin
            cap.push_back(w(int'(out_chain), out_last, int'(out_len), int'(out_data)));
            cap_cyc.push_back(cyc);
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [63:0] w(input int ch, input logic last, input int len, input int data);
        return (64'(ch) << 20) | (64'(last) << 16) | (64'(len) << 8) | 64'(data);
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h required %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge gclk);
        #1;
    endtask

    task automatic idle_inputs();
        ch_out      = '0;
        ch_out_vld  = '0;
        ch_out_done = '0;
        start       = 1'b0;
    endtask

    task automatic send_bits(input logic [CHAINS-1:0] mask, input logic [CHAINS-1:0][WORD_W-1:0] val,
                             input int nbits, input logic [CHAINS-1:0] done_last);
        for (int k = 0; k < nbits; k++) begin
            for (int c = 0; c < CHAINS; c++) ch_out[c] = val[c][k];
            ch_out_vld  = mask;
            ch_out_done = (k == nbits - 1) ? done_last : '0;
            tick();
        end
        idle_inputs();
    endtask

    task automatic send_done(input logic [CHAINS-1:0] mask);
        ch_out_done = mask;
        tick();
        idle_inputs();
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_words(input string tag, input int n);
        int t;
        t = 0;
        while (cap.size() < n && t < 200) begin
            tick();
            t++;
        end
        chk(tag, 64'(cap.size() >= n), 64'(1));
    endtask

    task automatic wait_done(input string tag);
        int t;
        t = 0;
        while (done !== 1'b1 && t < 200) begin
            tick();
            t++;
        end
        chk({tag, "_done"}, 64'(done), 64'(1));
        chk({tag, "_busy_low"}, 64'(busy), 64'(0));
        tick();
        chk({tag, "_done_1cyc"}, 64'(done), 64'(0));
    endtask

    initial begin
        arst_l    = 1'b0;
        out_ready = 1'b1;
        idle_inputs();

        // reset held with random inputs
        for (int n = 0; n < 4; n++) begin
            start       = 1'($urandom());
            ch_out      = 4'($urandom());
            ch_out_vld  = 4'($urandom());
            ch_out_done = 4'($urandom());
            tick();
            chk("rst_dump_en", 64'(dump_en), 64'(0));
            chk("rst_out_valid", 64'(out_valid), 64'(0));
            chk("rst_busy", 64'(busy), 64'(0));
            chk("rst_overflow", 64'(overflow), 64'(0));
        end
        idle_inputs();
        tick();
        arst_l = 1'b1;

        // chain activity without start must produce nothing
        for (int n = 0; n < 12; n++) begin
            ch_out      = 4'($urandom());
            ch_out_vld  = 4'($urandom());
            ch_out_done = 4'($urandom());
            tick();
        end
        idle_inputs();
        tick();
        tick();
        chk("idle_no_words", 64'(cap.size()), 64'(0));
        chk("idle_busy", 64'(busy), 64'(0));

        // chain 2: 0xA5 then 3-bit tail, other chains end empty
        pulse_start();
        chk("start_dump_en", 64'(dump_en), 64'hF);
        chk("start_busy", 64'(busy), 64'(1));
        send_bits(4'b0100, {8'h00, 8'hA5, 8'h00, 8'h00}, 8, 4'b0000);
        chk("lat_slot_only", 64'(out_valid), 64'(0));
        tick();
        chk("lat_out_valid", 64'(out_valid), 64'(1));
        chk("lat_out_data", 64'(out_data), 64'hA5);
        send_bits(4'b0100, {8'h00, 8'h05, 8'h00, 8'h00}, 3, 4'b0100);
        send_done(4'b1011);
        wait_done("dump1");
        chk("dump1_count", 64'(cap.size()), 64'(5));
        if (cap.size() >= 5) begin
            chk("dump1_w0", cap[0], w(2, 1'b0, 8, 'hA5));
            chk("dump1_w1", cap[1], w(2, 1'b1, 3, 'h05));
            chk("dump1_w2", cap[2], w(3, 1'b1, 0, 0));
            chk("dump1_w3", cap[3], w(0, 1'b1, 0, 0));
            chk("dump1_w4", cap[4], w(1, 1'b1, 0, 0));
        end

        // fresh reset so rr starts at 0, then simultaneous completions
        arst_l = 1'b0;
        tick();
        arst_l = 1'b1;
        cap.delete();
        cap_cyc.delete();
        pulse_start();
        send_bits(4'b1011, {8'h33, 8'h00, 8'h22, 8'h11}, 8, 4'b0000);
        wait_words("rr_wait3", 3);
        if (cap.size() >= 3) begin
            chk("rr_w0", cap[0], w(0, 1'b0, 8, 'h11));
            chk("rr_w1", cap[1], w(1, 1'b0, 8, 'h22));
            chk("rr_w2", cap[2], w(3, 1'b0, 8, 'h33));
            chk("rr_back2back_a", 64'(cap_cyc[1] - cap_cyc[0]), 64'(1));
            chk("rr_back2back_b", 64'(cap_cyc[2] - cap_cyc[1]), 64'(1));
        end
        cap.delete();
        cap_cyc.delete();
        send_bits(4'b1001, {8'h55, 8'h00, 8'h00, 8'h44}, 8, 4'b0000);
        wait_words("rr_wait2", 2);
        if (cap.size() >= 2) begin
            chk("rr_wrap_w0", cap[0], w(0, 1'b0, 8, 'h44));
            chk("rr_wrap_w1", cap[1], w(3, 1'b0, 8, 'h55));
        end
        cap.delete();
        send_done(4'hF);
        wait_done("dump2");
        chk("dump2_count", 64'(cap.size()), 64'(4));

        // stalled output: chain 1 completes three words, third is dropped
        cap.delete();
        out_ready = 1'b0;
        pulse_start();
        send_bits(4'b0010, {8'h00, 8'h00, 8'h01, 8'h00}, 8, 4'b0000);
        send_bits(4'b0010, {8'h00, 8'h00, 8'h02, 8'h00}, 8, 4'b0000);
        chk("stall_hold_a", 64'(out_data), 64'h01);
        send_bits(4'b0010, {8'h00, 8'h00, 8'h03, 8'h00}, 8, 4'b0000);
        tick();
        chk("stall_valid", 64'(out_valid), 64'(1));
        chk("stall_hold_b", {44'd0, 2'(out_chain), 1'(out_last), 4'(out_len), 8'(out_data)},
            {44'd0, 2'd1, 1'b0, 4'd8, 8'h01});
        chk("stall_overflow", 64'(overflow), 64'h2);
        out_ready = 1'b1;
        wait_words("stall_wait2", 2);
        tick();
        tick();
        tick();
        chk("stall_count", 64'(cap.size()), 64'(2));
        if (cap.size() >= 2) begin
            chk("stall_w0", cap[0], w(1, 1'b0, 8, 'h01));
            chk("stall_w1", cap[1], w(1, 1'b0, 8, 'h02));
        end
        chk("stall_ovf_sticky", 64'(overflow), 64'h2);
        send_done(4'hF);
        wait_done("dump3");
        chk("dump3_ovf_kept", 64'(overflow), 64'h2);

        // start in DUMP ignored, then reset mid-word
        cap.delete();
        pulse_start();
        chk("restart_ovf_clr", 64'(overflow), 64'(0));
        send_bits(4'b0001, {8'h00, 8'h00, 8'h00, 8'h06}, 4, 4'b0000);
        pulse_start();
        chk("ign_start_busy", 64'(busy), 64'(1));
        send_bits(4'b0001, {8'h00, 8'h00, 8'h00, 8'h09}, 4, 4'b0000);
        wait_words("ign_wait", 1);
        if (cap.size() >= 1) chk("ign_start_word", cap[0], w(0, 1'b0, 8, 'h96));
        out_ready = 1'b0;
        send_bits(4'b0001, {8'h00, 8'h00, 8'h00, 8'hFF}, 8, 4'b0000);
        tick();
        chk("pre_rst_valid", 64'(out_valid), 64'(1));
        send_bits(4'b0001, {8'h00, 8'h00, 8'h00, 8'h05}, 3, 4'b0000);
        arst_l = 1'b0;
        #1;
        chk("midrst_valid", 64'(out_valid), 64'(0));
        chk("midrst_data", 64'(out_data), 64'(0));
        chk("midrst_dump_en", 64'(dump_en), 64'(0));
        chk("midrst_busy", 64'(busy), 64'(0));
        tick();
        arst_l    = 1'b1;
        out_ready = 1'b1;
        cap.delete();
        pulse_start();
        send_bits(4'b0001, {8'h00, 8'h00, 8'h00, 8'h3C}, 8, 4'b0000);
        send_bits(4'b0001, {8'h00, 8'h00, 8'h00, 8'h03}, 2, 4'b0001);
        wait_words("clean_wait", 2);
        if (cap.size() >= 2) begin
            chk("clean_w0", cap[0], w(0, 1'b0, 8, 'h3C));
            chk("clean_w1", cap[1], w(0, 1'b1, 2, 'h03));
        end
        chk("clean_overflow", 64'(overflow), 64'(0));
        send_done(4'b1110);
        wait_done("dump4");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
